// File: rtl/pcie_app_reset_seq_if.sv
// Handshake bundle between the PCIe hard-IP status/control pins and the
// application reset sequencer; the sequencer uses the slave view.
interface pcie_app_reset_seq_if;
    logic       core_reset_status;
    logic       pll_locked;
    logic [4:0] ltssm;
    logic       core_reset_req;
    logic       app_rst_n;
    logic       link_up;
    logic       link_fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    modport master (
        output core_reset_status, pll_locked, ltssm,
        input  core_reset_req, app_rst_n, link_up, link_fail, retry_cnt, state
    );

    modport slave (
        input  core_reset_status, pll_locked, ltssm,
        output core_reset_req, app_rst_n, link_up, link_fail, retry_cnt, state
    );
endinterface

// File: rtl/pcie_app_reset_seq.sv
// Application reset sequencer: releases app_rst_n after core ready and stable L0,
// re-resets the hard IP on link-training timeout. Optional macro: PCIE_APP_RST_LINKDOWN_DEBOUNCE_EN.
module pcie_app_reset_seq #(
    parameter int unsigned HOLD_CYCLES     = 256,
    parameter int unsigned LINK_TIMEOUT    = 1000000,
    parameter int unsigned RETRY_MAX       = 3,
    parameter int unsigned PULSE_CYCLES    = 16,
    parameter logic [4:0]  LTSSM_L0        = 5'h0F,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input logic                 clk,
    input logic                 rst,
    pcie_app_reset_seq_if.slave bus
);

    typedef enum logic [2:0] {
        WAIT_CORE = 3'd0,
        WAIT_LINK = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        RESET_REQ = 3'd4,
        FAIL      = 3'd5
    } state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    localparam int unsigned CNT_MAX = max2(max2(LINK_TIMEOUT, HOLD_CYCLES),
                                           max2(PULSE_CYCLES, DEBOUNCE_CYCLES));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 32'd1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] LINK_LAST  = CNT_W'(LINK_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 32'd1);
`ifdef PCIE_APP_RST_LINKDOWN_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
`endif
    localparam logic [3:0]       RETRY_LIM  = 4'(RETRY_MAX);

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_step_s, cnt_nx_s;
    logic [3:0]       retry_r, retry_nx_s;
    logic             app_rst_n_r, link_up_r, link_fail_r, core_reset_req_r;
    logic             ready_s, l0_s;

    // Next-state, cycle counter and retry bookkeeping
    always_comb begin
        ready_s    = bus.pll_locked & ~bus.core_reset_status;
        l0_s       = ready_s & (bus.ltssm == LTSSM_L0);
        state_nx_s = state_r;
        cnt_step_s = cnt_r + CNT_ONE;
        retry_nx_s = retry_r;
        case (state_r)
            WAIT_CORE: begin
                cnt_step_s = CNT_ZERO;
                if (ready_s) begin
                    state_nx_s = WAIT_LINK;
                end else begin
                    state_nx_s = WAIT_CORE;
                end
            end
            WAIT_LINK: begin
                // l0 beats ~ready, and both beat the timeout
                if (l0_s) begin
                    state_nx_s = HOLD;
                end else if (!ready_s) begin
                    state_nx_s = WAIT_CORE;
                end else if (cnt_r == LINK_LAST) begin
                    if (retry_r < RETRY_LIM) begin
                        state_nx_s = RESET_REQ;
                        retry_nx_s = retry_r + 4'd1;
                    end else begin
                        state_nx_s = FAIL;
                    end
                end else begin
                    state_nx_s = WAIT_LINK;
                end
            end
            HOLD: begin
                if (!l0_s) begin
                    state_nx_s = WAIT_LINK;
                end else if (cnt_r == HOLD_LAST) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            RUN: begin
`ifdef PCIE_APP_RST_LINKDOWN_DEBOUNCE_EN
                // Loss of core readiness is never filtered; only LTSSM drops are
                if (!ready_s) begin
                    state_nx_s = WAIT_CORE;
                end else if (l0_s) begin
                    cnt_step_s = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_nx_s = WAIT_CORE;
                end else begin
                    state_nx_s = RUN;
                end
`else
                cnt_step_s = CNT_ZERO;
                if (!l0_s) begin
                    state_nx_s = WAIT_CORE;
                end else begin
                    state_nx_s = RUN;
                end
`endif
            end
            RESET_REQ: begin
                if (cnt_r == PULSE_LAST) begin
                    state_nx_s = WAIT_CORE;
                end else begin
                    state_nx_s = RESET_REQ;
                end
            end
            FAIL: begin
                state_nx_s = FAIL;
                cnt_step_s = CNT_ZERO;
            end
            default: begin
                state_nx_s = WAIT_CORE;
                cnt_step_s = CNT_ZERO;
            end
        endcase
        if (state_nx_s != state_r) begin
            cnt_nx_s = CNT_ZERO;
        end else begin
            cnt_nx_s = cnt_step_s;
        end
    end

    // State, counters and registered outputs; rst drops everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= WAIT_CORE;
            cnt_r            <= CNT_ZERO;
            retry_r          <= 4'd0;
            app_rst_n_r      <= 1'b0;
            link_up_r        <= 1'b0;
            link_fail_r      <= 1'b0;
            core_reset_req_r <= 1'b0;
        end else begin
            state_r          <= state_nx_s;
            cnt_r            <= cnt_nx_s;
            retry_r          <= retry_nx_s;
            app_rst_n_r      <= (state_nx_s == RUN);
            link_up_r        <= (state_nx_s == RUN);
            link_fail_r      <= (state_nx_s == FAIL);
            core_reset_req_r <= (state_nx_s == RESET_REQ);
        end
    end

    assign bus.state          = state_r;
    assign bus.retry_cnt      = retry_r;
    assign bus.app_rst_n      = app_rst_n_r;
    assign bus.link_up        = link_up_r;
    assign bus.link_fail      = link_fail_r;
    assign bus.core_reset_req = core_reset_req_r;

endmodule

// File: tb/tb_pcie_app_reset_seq.sv
// Self-checking bench for pcie_app_reset_seq: directed scenarios plus random
// stimulus against a cycle-count reference model.
module tb_pcie_app_reset_seq;
    localparam int HOLD = 8, TMO = 32, RMAX = 2, PULSE = 4, DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;

    pcie_app_reset_seq_if bus();

    pcie_app_reset_seq #(
        .HOLD_CYCLES(HOLD), .LINK_TIMEOUT(TMO), .RETRY_MAX(RMAX),
        .PULSE_CYCLES(PULSE), .LTSSM_L0(5'h0F), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    wire [10:0] obs = {bus.state, bus.retry_cnt, bus.link_fail, bus.link_up,
                       bus.app_rst_n, bus.core_reset_req};

    // Reference model: phase number plus plain counts of how long each condition has held
    int m_phase, m_wait, m_good, m_bad, m_pulse, m_retry;

    function automatic void m_go(int p);
        m_phase = p; m_wait = 0; m_good = 0; m_bad = 0;
        m_pulse = (p == 4) ? PULSE : 0;
    endfunction

    function automatic void model_reset();
        m_go(0);
        m_retry = 0;
    endfunction

    function automatic void model_step();
        bit ready, l0;
        ready = bus.pll_locked && !bus.core_reset_status;
        l0    = ready && (bus.ltssm == 5'h0F);
        case (m_phase)
            0: if (ready) m_go(1);
            1: begin
                if (l0) m_go(2);
                else if (!ready) m_go(0);
                else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        if (m_retry < RMAX) begin m_retry++; m_go(4); end
                        else m_go(5);
                    end
                end
            end
            2: begin
                if (!l0) m_go(1);
                else begin m_good++; if (m_good == HOLD) m_go(3); end
            end
            3: begin
`ifdef PCIE_APP_RST_LINKDOWN_DEBOUNCE_EN
                if (!ready) m_go(0);
                else if (l0) m_bad = 0;
                else begin m_bad++; if (m_bad == DEB) m_go(0); end
`else
                if (!l0) m_go(0);
`endif
            end
            4: begin m_pulse--; if (m_pulse == 0) m_go(0); end
            5: ;
            default: m_go(0);
        endcase
    endfunction

    function automatic logic [10:0] exp_vec();
        return {3'(m_phase), 4'(m_retry), m_phase == 5, m_phase == 3, m_phase == 3, m_phase == 4};
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (!rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic drive(input logic pll, input logic st, input logic [4:0] lt);
        bus.pll_locked        = pll;
        bus.core_reset_status = st;
        bus.ltssm             = lt;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic bring_to_run();
        drive(1'b1, 1'b0, 5'h0F);
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 5'h0F);
        rst = 1'b0;
        #3;
        n_tests++;
        if (obs !== 11'd0) begin n_fail++; $display("FAIL reset_async got=%h exp=%h", obs, 11'd0); end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (obs !== 11'd0) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, 11'd0); end
        end
        rst = 1'b1;
    endtask

    task automatic test_bringup();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            drive(c >= 5, !(c >= 5), (c >= 10) ? 5'h0F : 5'h00);
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL bringup_model edge=%0d got=%h exp=%h", c + 1, obs, exp_vec()); end
            n_tests++;
            if (bus.core_reset_req !== 1'b0) begin n_fail++; $display("FAIL bringup_noreq edge=%0d got=%b exp=0", c + 1, bus.core_reset_req); end
            if (c == 10) begin
                n_tests++;
                if (bus.state !== 3'd2) begin n_fail++; $display("FAIL bringup_hold_entry got=%0d exp=2", bus.state); end
            end
            if (c == 17) begin
                n_tests++;
                if (bus.app_rst_n !== 1'b0) begin n_fail++; $display("FAIL bringup_early_release got=%b exp=0", bus.app_rst_n); end
            end
            if (c == 18) begin
                n_tests++;
                if ({bus.app_rst_n, bus.link_up} !== 2'b11) begin n_fail++; $display("FAIL bringup_release got=%b exp=11", {bus.app_rst_n, bus.link_up}); end
            end
        end
    endtask

    task automatic test_hold_glitch();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c == 0) drive(1'b1, 1'b0, 5'h00);
            else if (c == 7) drive(1'b1, 1'b0, 5'h01);
            else drive(1'b1, 1'b0, 5'h0F);
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL glitch_model edge=%0d got=%h exp=%h", c + 1, obs, exp_vec()); end
            if (c == 7 || c == 15) begin
                n_tests++;
                if (bus.app_rst_n !== 1'b0) begin n_fail++; $display("FAIL glitch_no_release edge=%0d got=%b exp=0", c + 1, bus.app_rst_n); end
            end
            if (c == 16) begin
                n_tests++;
                if (bus.app_rst_n !== 1'b1) begin n_fail++; $display("FAIL glitch_release got=%b exp=1", bus.app_rst_n); end
            end
        end
    endtask

    task automatic test_timeout_retry();
        int pulses = 0;
        int first_edge = -1;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            drive(1'b1, 1'b0, 5'h02);
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL timeout_model edge=%0d got=%h exp=%h", c + 1, obs, exp_vec()); end
            if (bus.core_reset_req === 1'b1) begin
                pulses++;
                if (first_edge < 0) begin
                    first_edge = c + 1;
                    n_tests++;
                    if (bus.retry_cnt !== 4'd1) begin n_fail++; $display("FAIL timeout_retry1 got=%0d exp=1", bus.retry_cnt); end
                end
            end
        end
        n_tests++;
        if (first_edge !== 33) begin n_fail++; $display("FAIL timeout_first_pulse_edge got=%0d exp=33", first_edge); end
        n_tests++;
        if (pulses !== 2 * PULSE) begin n_fail++; $display("FAIL timeout_pulse_cycles got=%0d exp=%0d", pulses, 2 * PULSE); end
        n_tests++;
        if ({bus.state, bus.link_fail, bus.app_rst_n, bus.retry_cnt} !== {3'd5, 1'b1, 1'b0, 4'd2}) begin
            n_fail++; $display("FAIL timeout_final got=%h exp=%h", {bus.state, bus.link_fail, bus.app_rst_n, bus.retry_cnt}, {3'd5, 1'b1, 1'b0, 4'd2});
        end
    endtask

    task automatic test_linkdown_run();
        logic exp_app;
        do_reset();
        bring_to_run();
        n_tests++;
        if (bus.link_up !== 1'b1) begin n_fail++; $display("FAIL linkdown_pre_run got=%b exp=1", bus.link_up); end
        drive(1'b1, 1'b0, 5'h01);
        tick();
`ifdef PCIE_APP_RST_LINKDOWN_DEBOUNCE_EN
        exp_app = 1'b1;
`else
        exp_app = 1'b0;
`endif
        n_tests++;
        if (bus.app_rst_n !== exp_app) begin n_fail++; $display("FAIL linkdown_1cyc got=%b exp=%b", bus.app_rst_n, exp_app); end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL linkdown_model got=%h exp=%h", obs, exp_vec()); end
        bring_to_run();
`ifdef PCIE_APP_RST_LINKDOWN_DEBOUNCE_EN
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 5'h01);
            tick();
            exp_app = (i < 3);
            n_tests++;
            if (bus.app_rst_n !== exp_app) begin n_fail++; $display("FAIL linkdown_4cyc i=%0d got=%b exp=%b", i, bus.app_rst_n, exp_app); end
        end
`endif
    endtask

    task automatic test_pll_loss();
        do_reset();
        bring_to_run();
        drive(1'b0, 1'b0, 5'h0F);
        tick();
        n_tests++;
        if ({bus.app_rst_n, bus.state} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL pll_loss got=%h exp=%h", {bus.app_rst_n, bus.state}, {1'b0, 3'd0}); end
    endtask

    task automatic test_async_mid_pulse();
        bit seen = 1'b0;
        do_reset();
        drive(1'b1, 1'b0, 5'h02);
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if (bus.core_reset_req === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL midpulse_no_pulse got=0 exp=1"); end
        tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({bus.core_reset_req, bus.state, bus.retry_cnt, bus.app_rst_n} !== 9'd0) begin
            n_fail++; $display("FAIL midpulse_async got=%h exp=%h", {bus.core_reset_req, bus.state, bus.retry_cnt, bus.app_rst_n}, 9'd0);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] lt_cur = 5'h0F;
        logic [4:0] lt;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) lt_cur = ($urandom_range(0, 9) < 7) ? 5'h0F : 5'($urandom_range(0, 31));
            lt = ($urandom_range(0, 29) == 0) ? 5'($urandom_range(0, 31)) : lt_cur;
            drive($urandom_range(0, 31) != 0, $urandom_range(0, 31) == 0, lt);
            if ($urandom_range(0, 699) == 0) do_reset();
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_model edge=%0d got=%h exp=%h", edge_n, obs, exp_vec()); end
        end
    endtask

    initial begin
        drive(1'b0, 1'b1, 5'h00);
        test_reset();
        test_bringup();
        test_hold_glitch();
        test_timeout_retry();
        test_linkdown_run();
        test_pll_loss();
        test_async_mid_pulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pcie_app_reset_seq.md
Name: pcie_app_reset_seq

Overview:
Sits directly downstream of the PCIe reset conditioner. It takes the conditioned npor, used as this block's rst, plus hard-IP status, and sequences release of the application-side reset only after the core is out of reset, the PLL is locked and the link has been stably in L0.
On link-training timeout it pulses a request back into the reset conditioner's reset input to re-reset the hard IP, with bounded retries, and reports a sticky failure when retries run out.

Parameters:
HOLD_CYCLES, 256, consecutive L0 cycles required before app reset release (>=2)
LINK_TIMEOUT, 1000000, max cycles in WAIT_LINK before a re-reset is requested (>=2)
RETRY_MAX, 3, number of re-reset attempts before FAIL (0..15)
PULSE_CYCLES, 16, width of core_reset_req pulse (>=1)
LTSSM_L0, 5'h0F, LTSSM encoding for L0
DEBOUNCE_CYCLES, 16, link-down filter length; used only with the optional feature

Ports:
clk  in  1  sequencer clock, same domain as all inputs
rst  in  1  asynchronous active-low reset, driven from conditioned npor
core_reset_status  in  1  hard-IP reset status, high = core in reset
pll_locked  in  1  SERDES/core PLL lock
ltssm  in  5  LTSSM state from hard IP
core_reset_req  out  1  high = request re-reset of hard IP; feeds reset conditioner reset input
app_rst_n  out  1  application reset, active-low
link_up  out  1  high while in RUN
link_fail  out  1  sticky; high in FAIL
retry_cnt  out  4  re-reset attempts since rst
state  out  3  encoded FSM state: WAIT_CORE=0, WAIT_LINK=1, HOLD=2, RUN=3, RESET_REQ=4, FAIL=5

Behaviour:
- Reset is decided as follows: rst asynchronous, active-low; clock clk.
- While rst=0, all outputs hold these values:
  - state=WAIT_CORE
  - app_rst_n=0, core_reset_req=0, link_up=0, link_fail=0
  - retry_cnt=0, all counters=0
- All outputs are registered. The FSM evaluates inputs in cycle N, and the new state and outputs are visible after edge N+1.
- "ready" = pll_locked & ~core_reset_status.
- "l0" = ready & (ltssm==LTSSM_L0).
- WAIT_CORE: go to WAIT_LINK when ready. Clear cnt.
- WAIT_LINK:
  - If l0, go to HOLD with cnt=0.
  - Else if ~ready, go to WAIT_CORE.
  - Else cnt++. When cnt==LINK_TIMEOUT-1 with no l0:
    - if retry_cnt<RETRY_MAX, go to RESET_REQ and retry_cnt++;
    - otherwise go to FAIL.
- HOLD:
  - If ~l0, go to WAIT_LINK with cnt=0. The timeout window restarts in full.
  - Else cnt++. When cnt==HOLD_CYCLES-1, go to RUN.
  - app_rst_n rises exactly HOLD_CYCLES edges after HOLD entry.
- RUN:
  - app_rst_n=1, link_up=1.
  - On ~l0, next edge gives app_rst_n=0, link_up=0 and state=WAIT_CORE (without debounce).
  - retry_cnt is not cleared by a successful link-up.
- RESET_REQ:
  - core_reset_req=1 for exactly PULSE_CYCLES cycles, then go to WAIT_CORE.
  - Inputs are ignored during the pulse.
- FAIL: core_reset_req=0, app_rst_n=0, link_fail=1. Only rst exits.
- app_rst_n=1 only in RUN; it is 0 in every other state.
- cnt is sized for max(LINK_TIMEOUT, HOLD_CYCLES, PULSE_CYCLES, DEBOUNCE_CYCLES) and never wraps. It is cleared on every state change.
- Simultaneous events:
  - In WAIT_LINK, l0 in the timeout cycle takes priority and goes to HOLD.
  - ~ready takes priority over the timeout.
- RETRY_MAX=0: the first timeout goes directly to FAIL with no request pulse.
- rst asserted mid-operation, including mid-pulse: core_reset_req drops asynchronously and everything resets.

Optional Feature:
- Macro: PCIE_APP_RST_LINKDOWN_DEBOUNCE_EN.
- Defined:
  - In RUN, ~l0 must persist DEBOUNCE_CYCLES consecutive cycles before leaving RUN. Any l0 cycle clears the debounce count.
  - core_reset_status=1 or pll_locked=0 still leaves RUN on the next edge without debounce.
- Undefined: leave RUN on the first ~l0 cycle; the debounce counter and logic are absent.

Test Plan (HOLD_CYCLES=8, LINK_TIMEOUT=32, RETRY_MAX=2, PULSE_CYCLES=4, DEBOUNCE_CYCLES=4):
- Normal bring-up: rst release, ready at cycle 5, ltssm=0x0F at cycle 10 -> HOLD entered edge 11, app_rst_n=1 and link_up=1 at edge 19, core_reset_req never high.
- HOLD glitch: ltssm leaves L0 for 1 cycle after 5 HOLD cycles -> back to WAIT_LINK, no release, then full 8 further L0 cycles needed.
- Timeout and retry: ready, ltssm=0x02 forever -> core_reset_req high 4 cycles after 32 WAIT_LINK cycles, retry_cnt=1. Repeats once more (retry_cnt=2). Third timeout gives link_fail=1, state=5, app_rst_n=0, no further pulses.
- Link-down in RUN: ltssm drops to 0x01 for 1 cycle -> without macro, app_rst_n=0 next edge, state=WAIT_CORE. With macro, app_rst_n stays 1. With macro and a 4-cycle drop, app_rst_n=0 after the 4th cycle.
- PLL loss in RUN: pll_locked=0 -> app_rst_n=0 next edge in both builds.
- Async reset mid-pulse: assert rst during core_reset_req -> core_reset_req=0 immediately, retry_cnt=0, state=0.
